mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 113 +++++++++++
 tb/tb_mem_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port (instruction/data) arbiter onto a single registered memory bus.
// Define MEM_ARB_RR_EN for round-robin arbitration; default is fixed data-port priority.
module mem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_rdata,
  output logic          i_ready,
  input  logic          d_read,
  input  logic          d_write,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ready,
  output logic          mem_read,
  output logic          mem_write,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic          grant_d
);

  typedef enum logic [1:0] {IDLE, I_ACC, D_ACC} state_t;

  state_t state, state_nx;
  logic   i_rq, d_rq, pick_d;

  // A port whose ready pulse is high this cycle is still holding its request.
  assign i_rq = i_req & ~i_ready;
  assign d_rq = (d_read | d_write) & ~d_ready;

`ifdef MEM_ARB_RR_EN
  logic rr_pref_d;

  assign pick_d = d_rq & (~i_rq | rr_pref_d);

  // Pointer only moves when both ports compete; the loser is preferred next time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                rr_pref_d <= 1'b1;
    else if (state == IDLE && i_rq && d_rq) rr_pref_d <= ~pick_d;
  end
`else
  assign pick_d = d_rq;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (pick_d)    state_nx = D_ACC;
        else if (i_rq) state_nx = I_ACC;
      end
      I_ACC, D_ACC: if (mem_ready) state_nx = IDLE;
      default:      state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      i_rdata   <= '0;
      d_rdata   <= '0;
      i_ready   <= 1'b0;
      d_ready   <= 1'b0;
    end else begin
      i_ready <= 1'b0;
      d_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_d) begin
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            mem_write <= d_write;
            mem_read  <= ~d_write;
          end else if (i_rq) begin
            mem_addr  <= i_addr;
            mem_read  <= 1'b1;
            mem_write <= 1'b0;
          end
        end
        I_ACC: if (mem_ready) begin
          i_rdata   <= mem_rdata;
          i_ready   <= 1'b1;
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
        end
        D_ACC: if (mem_ready) begin
          d_rdata   <= mem_rdata;
          d_ready   <= 1'b1;
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign grant_d = (state == D_ACC);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: table-driven single accesses, directed corner
// sequences and randomized request rounds against a transaction-level model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic [31:0] i_rdata;
  logic        i_ready;
  logic        d_read = 1'b0, d_write = 1'b0;
  logic [31:0] d_addr = '0, d_wdata = '0;
  logic [31:0] d_rdata;
  logic        d_ready;
  logic        mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;
  logic        grant_d;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_i = '0, last_d = '0;
  bit          rr_pref_d = 1'b1;

  mem_arbiter #(.AW(32), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .grant_d(grant_d)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Exclusivity invariants, sampled mid-cycle.
  always @(negedge clk) if (!rst) begin
    chk("both_ready", {31'd0, i_ready & d_ready}, 32'd0);
    chk("both_strobes", {31'd0, mem_read & mem_write}, 32'd0);
  end

  task automatic do_reset();
    rst = 1'b1; i_req = 0; d_read = 0; d_write = 0; mem_ready = 0;
    tick(); tick();
    rst = 1'b0;
    last_i = '0; last_d = '0; rr_pref_d = 1'b1;
  endtask

  // Model arbitration: fixed data priority, or round-robin on contested grants.
  function automatic bit model_pick_d(input bit ri, input bit rd);
    bit w;
    w = rd;
`ifdef MEM_ARB_RR_EN
    if (ri && rd) begin
      w = rr_pref_d;
      rr_pref_d = ~w;
    end
`endif
    return w;
  endfunction

  // Serve one access of the expected owner with a memory latency of lat cycles.
  task automatic do_access(input bit od, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [31:0] rd, input int lat, input bit er, input bit ew);
    int w, cnt;
    w = 0; cnt = 0;
    while (!(mem_read || mem_write) && w < 20) begin tick(); w++; end
    if (!(mem_read || mem_write)) begin
      chk("grant_timeout", 32'd0, 32'd1);
      return;
    end
    chk("mem_addr", mem_addr, addr);
    chk("mem_read", {31'd0, mem_read}, {31'd0, er});
    chk("mem_write", {31'd0, mem_write}, {31'd0, ew});
    if (ew) chk("mem_wdata", mem_wdata, wd);
    chk("grant_d", {31'd0, grant_d}, {31'd0, od});
    if (od) begin d_addr = $urandom; d_wdata = $urandom; end
    else i_addr = $urandom;
    for (int c = 1; c <= lat; c++) begin
      if (mem_read === er && mem_write === ew) cnt++;
      chk("hold_addr", mem_addr, addr);
      if (ew) chk("hold_wdata", mem_wdata, wd);
      chk("early_ready", {30'd0, i_ready, d_ready}, 32'd0);
      mem_ready = (c == lat);
      mem_rdata = (c == lat) ? rd : $urandom;
      tick();
    end
    mem_ready = 1'b0;
    chk("strobe_cycles", cnt, lat);
    chk("strobes_clear", {30'd0, mem_read, mem_write}, 32'd0);
    chk("grant_d_idle", {31'd0, grant_d}, 32'd0);
    if (od) begin
      chk("d_ready", {31'd0, d_ready}, 32'd1);
      chk("i_ready_off", {31'd0, i_ready}, 32'd0);
      chk("d_rdata", d_rdata, rd);
      chk("i_rdata_hold", i_rdata, last_i);
      last_d = rd; d_read = 0; d_write = 0;
    end else begin
      chk("i_ready", {31'd0, i_ready}, 32'd1);
      chk("d_ready_off", {31'd0, d_ready}, 32'd0);
      chk("i_rdata", i_rdata, rd);
      chk("d_rdata_hold", d_rdata, last_d);
      last_i = rd; i_req = 0;
    end
    tick();
    chk("ready_one_cycle", {31'd0, od ? d_ready : i_ready}, 32'd0);
  endtask

  typedef struct {
    bit          od, rd, wr;
    logic [31:0] addr, wdata, rdata;
    int          lat;
    bit          exp_rd, exp_wr;
  } vec_t;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{1'b0, 1'b1, 1'b0, 32'h100,      32'h0,  32'hDEADBEEF, 3, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 32'h200,      32'h0,  32'h12345678, 1, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 32'h40,       32'h5,  32'hCAFEF00D, 2, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 32'h80,       32'hA5, 32'h0BADF00D, 1, 1'b0, 1'b1};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 32'hFFFFFFFC, 32'h0,  32'h87654321, 4, 1'b1, 1'b0};

    #1;
    chk("rst_strobes", {30'd0, mem_read, mem_write}, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_rdata", i_rdata | d_rdata, 32'd0);
    chk("rst_readies", {29'd0, i_ready, d_ready, grant_d}, 32'd0);
    do_reset();

    // Single-access vectors
    foreach (vecs[k]) begin
      if (vecs[k].od) begin
        d_read = vecs[k].rd; d_write = vecs[k].wr;
        d_addr = vecs[k].addr; d_wdata = vecs[k].wdata;
      end else begin
        i_req = 1'b1; i_addr = vecs[k].addr;
      end
      do_access(vecs[k].od, vecs[k].addr, vecs[k].wdata, vecs[k].rdata,
                vecs[k].lat, vecs[k].exp_rd, vecs[k].exp_wr);
    end

    // Simultaneous requests, two rounds from reset
    do_reset();
    for (int r = 0; r < 2; r++) begin
      bit first_d;
      i_req = 1; i_addr = 32'h300 + r;
      d_write = 1; d_addr = 32'h40; d_wdata = 32'h5;
      first_d = model_pick_d(1'b1, 1'b1);
      if (r == 0) chk("first_round_owner", {31'd0, first_d}, 32'd1);
      if (first_d) begin
        do_access(1'b1, 32'h40, 32'h5, 32'h11, 2, 1'b0, 1'b1);
        do_access(1'b0, 32'h300 + r, 32'h0, 32'h22, 1, 1'b1, 1'b0);
      end else begin
        do_access(1'b0, 32'h300 + r, 32'h0, 32'h33, 1, 1'b1, 1'b0);
        do_access(1'b1, 32'h40, 32'h5, 32'h44, 2, 1'b0, 1'b1);
      end
    end

    // Reset during the second D_ACC cycle
    do_reset();
    d_write = 1; d_addr = 32'h40; d_wdata = 32'h77;
    for (int w = 0; w < 5 && !mem_write; w++) tick();
    chk("pre_rst_write", {31'd0, mem_write}, 32'd1);
    tick();
    rst = 1'b1; #1;
    chk("rst_mid_strobes", {30'd0, mem_read, mem_write}, 32'd0);
    chk("rst_mid_grant", {31'd0, grant_d}, 32'd0);
    chk("rst_mid_addr", mem_addr, 32'd0);
    d_write = 0;
    tick(); tick();
    rst = 1'b0; last_i = '0; last_d = '0; rr_pref_d = 1'b1;
    // mem_ready held high while idle must not produce a ready
    mem_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      chk("idle_ready", {30'd0, i_ready, d_ready}, 32'd0);
      chk("idle_strobes", {30'd0, mem_read, mem_write}, 32'd0);
    end
    mem_ready = 1'b0;
    d_read = 1; d_write = 1; d_addr = 32'h84; d_wdata = 32'h99;
    do_access(1'b1, 32'h84, 32'h99, 32'h55, 2, 1'b0, 1'b1);

    // Randomized rounds
    for (int r = 0; r < 40; r++) begin
      bit ri, rdr, rdw, fd;
      logic [31:0] ia, da, dw, ir, dr;
      int il, dl;
      ri = $urandom_range(0, 1); rdr = $urandom_range(0, 1); rdw = $urandom_range(0, 1);
      if (!ri && !rdr && !rdw) ri = 1;
      ia = $urandom; da = $urandom; dw = $urandom; ir = $urandom; dr = $urandom;
      il = $urandom_range(1, 4); dl = $urandom_range(1, 4);
      i_req = ri; i_addr = ia;
      d_read = rdr; d_write = rdw; d_addr = da; d_wdata = dw;
      fd = model_pick_d(ri, rdr | rdw);
      if (fd) begin
        do_access(1'b1, da, dw, dr, dl, ~rdw, rdw);
        if (ri) do_access(1'b0, ia, 32'h0, ir, il, 1'b1, 1'b0);
      end else begin
        do_access(1'b0, ia, 32'h0, ir, il, 1'b1, 1'b0);
        if (rdr | rdw) do_access(1'b1, da, dw, dr, dl, ~rdw, rdw);
      end
      mem_ready = $urandom_range(0, 1);
      tick();
      chk("rand_idle_ready", {30'd0, i_ready, d_ready}, 32'd0);
      mem_ready = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
